// File: rtl/butterfly_pipe_pkg.sv
// butterfly_pipe_pkg: shared Q-format, rounding-offset and saturation helpers.
package butterfly_pipe_pkg;

    // Twiddle fraction bits: +1.0 is 2^(tw_w-2).
    function automatic int q_frac(input int tw_w);
        return tw_w - 2;
    endfunction

    // Half an LSB of the product scale, added before the shift.
    function automatic int rnd_off(input int tw_w);
        return 1 << (tw_w - 3);
    endfunction

    function automatic int sat_clip(input int x, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return x > hi ? hi : (x < lo ? lo : x);
    endfunction

endpackage

// File: rtl/butterfly_pipe_twiddle_rom.sv
// twiddle_rom: combinational W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) lookup.
module twiddle_rom
    import butterfly_pipe_pkg::*;
#(
    parameter int TW_W  = 12,
    parameter int IDX_W = 3
) (
    input  logic        [IDX_W-1:0] index,
    output logic signed [TW_W-1:0]  w_re,
    output logic signed [TW_W-1:0]  w_im
);
    localparam int  HALF = 1 << IDX_W;
    localparam real ONE  = 2.0 ** q_frac(TW_W);
    localparam real PI   = 3.14159265358979323846;

    function automatic int rnd(input real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    logic signed [TW_W-1:0] rom_re [HALF];
    logic signed [TW_W-1:0] rom_im [HALF];

    for (genvar k = 0; k < HALF; k++) begin : g_rom
        localparam real C = ONE * $cos(PI * k / HALF);
        localparam real S = -ONE * $sin(PI * k / HALF);
        assign rom_re[k] = TW_W'(rnd(C));
        assign rom_im[k] = TW_W'(rnd(S));
    end

    assign w_re = rom_re[index];
    assign w_im = rom_im[index];
endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 4-stage radix-2 DIT butterfly with optional /2 scaling,
// round-half-up, output saturation and a sticky overflow flag.
module butterfly_pipe
    import butterfly_pipe_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int TW_W   = 12,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic        [IDX_W-1:0]  index,
    input  logic                     scale,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] m_re,
    output logic signed [DATA_W-1:0] m_im,
    output logic signed [DATA_W-1:0] n_re,
    output logic signed [DATA_W-1:0] n_im,
    output logic                     sat,
    output logic                     ovf
);
    localparam int PW   = DATA_W + TW_W;
    localparam int EW   = DATA_W + 2;
    localparam int FRAC = q_frac(TW_W);
    localparam logic signed [PW:0] RND = (PW + 1)'(rnd_off(TW_W));

    logic signed [TW_W-1:0]   w_re, w_im, w1_re, w1_im;
    logic signed [DATA_W-1:0] a1_re, a1_im, b1_re, b1_im, a2_re, a2_im, a3_re, a3_im;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic signed [PW:0]       tr_f, ti_f;
    logic signed [EW-1:0]     t3_re, t3_im;
    logic signed [EW-1:0]     s [4];
    logic signed [EW-1:0]     v [4];
    int                       c [4];
    logic                     v1, v2, v3, sc1, sc2, sc3, sat_n;

    twiddle_rom #(.TW_W(TW_W), .IDX_W(IDX_W)) u_rom (
        .index(index),
        .w_re (w_re),
        .w_im (w_im)
    );

    assign tr_f = (PW + 1)'(p_rr) - (PW + 1)'(p_ii) + RND;
    assign ti_f = (PW + 1)'(p_ri) + (PW + 1)'(p_ir) + RND;

    // Order: m_re, m_im, n_re, n_im.
    always_comb begin
        s[0] = EW'(a3_re) + t3_re;
        s[1] = EW'(a3_im) + t3_im;
        s[2] = EW'(a3_re) - t3_re;
        s[3] = EW'(a3_im) - t3_im;
        sat_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v[i] = sc3 ? (s[i] + EW'(1)) >>> 1 : s[i];
            c[i] = sat_clip(int'(v[i]), DATA_W);
            sat_n = sat_n | (c[i] != int'(v[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, v3, sc1, sc2, sc3} <= '0;
            {a1_re, a1_im, b1_re, b1_im, w1_re, w1_im} <= '0;
            {p_rr, p_ii, p_ri, p_ir, a2_re, a2_im} <= '0;
            {t3_re, t3_im, a3_re, a3_im} <= '0;
            {out_valid, m_re, m_im, n_re, n_im, sat} <= '0;
        end else if (en) begin
            {v1, sc1, a1_re, a1_im, b1_re, b1_im} <= {in_valid, scale, a_re, a_im, b_re, b_im};
            {w1_re, w1_im} <= {w_re, w_im};
            p_rr <= b1_re * w1_re;
            p_ii <= b1_im * w1_im;
            p_ri <= b1_re * w1_im;
            p_ir <= b1_im * w1_re;
            {v2, sc2, a2_re, a2_im} <= {v1, sc1, a1_re, a1_im};
            t3_re <= EW'(tr_f >>> FRAC);
            t3_im <= EW'(ti_f >>> FRAC);
            {v3, sc3, a3_re, a3_im} <= {v2, sc2, a2_re, a2_im};
            out_valid <= v3;
            if (v3) begin
                m_re <= DATA_W'(c[0]);
                m_im <= DATA_W'(c[1]);
                n_re <= DATA_W'(c[2]);
                n_im <= DATA_W'(c[3]);
                sat  <= sat_n;
            end
        end
    end

    // A set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else        ovf <= (out_valid && sat) || (ovf && !ovf_clr);
    end
endmodule
